mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 64: data width of the unified memory and the DM path; SHALL be ≥64.
REQ-002 Parameter AW, default 10: byte-address width of im_addr and dm_addr.
REQ-003 Parameter LAT, default 2, range 1..7: cycles from mem_en high to mem_rdata valid.
REQ-004 CLOCK_50  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset).
REQ-006 im_req  in  1  instruction fetch request; level, held until im_ready.
REQ-007 im_addr  in  AW  fetch byte address; stable while im_req.
REQ-008 im_rdata  out  32  fetched instruction, registered.
REQ-009 im_ready  out  1  one-cycle pulse, fetch complete.
REQ-010 dm_read, dm_write  in  1 each  data request; level, held until dm_ready.
REQ-011 dm_addr  in  AW  data byte address; dm_wdata  in  N  store data.
REQ-012 dm_rdata  out  N  load data, registered; dm_ready  out  1  one-cycle pulse, data access complete.
REQ-013 mem_en, mem_we  out  1 each  memory strobe and write enable, registered.
REQ-014 mem_addr  out  AW-3  doubleword address = request address[AW-1:3]; mem_wdata  out  N.
REQ-015 mem_rdata  in  N  memory read data, valid in the LAT-th cycle after the mem_en cycle.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: on a pending request, latch granted master, address, write flag and wdata; go to ISSUE; otherwise stay.
REQ-019 ISSUE: mem_en=1 for exactly one cycle; mem_we=1 only for a DM write; go to WAIT, loading the latency counter with LAT-1.
REQ-020 WAIT: counter decrements each cycle; mem_en=0; at 0, sample mem_rdata and go to RESP (LAT=1: WAIT lasts one cycle).
REQ-021 RESP: pulse im_ready or dm_ready (granted master only) for one cycle; go to IDLE without sampling requests.
REQ-022 Latency: a request first seen in IDLE at cycle t SHALL produce ready in cycle t+LAT+2; back-to-back issue rate one access per LAT+3 cycles.
REQ-023 Arbitration: only one pending requester is granted; when both pend, grant the master not granted last (round-robin); last_grant resets to IM, so the first tie goes to DM.
REQ-024 dm_read and dm_write both high SHALL be treated as a write; the read is ignored.
REQ-025 IM fetch: im_rdata = mem_rdata[31:0] if im_addr[2]=0, else mem_rdata[63:32]; dm_rdata unchanged.
REQ-026 DM read: dm_rdata = mem_rdata; im_rdata unchanged.
REQ-027 DM write: no rdata register changes; dm_ready still pulses in RESP as the write acknowledgement.
REQ-028 Request inputs SHALL be ignored outside IDLE; a request dropped before grant is lost without error.
REQ-029 mem_addr and mem_wdata SHALL hold the latched values from ISSUE through RESP.

Reset
REQ-030 While reset=0: state IDLE, counter 0, last_grant IM.
REQ-031 While reset=0: mem_en, mem_we, im_ready, dm_ready, busy = 0; im_rdata, dm_rdata, mem_addr, mem_wdata = 0.
REQ-032 Reset asserted mid-access (ISSUE/WAIT/RESP) SHALL abort it: no ready pulse, in-flight read data discarded.
REQ-033 After release, the first rising edge samples requests in IDLE.

Verification
REQ-034 LAT=2, im_req with im_addr=0x004, memory word 0x1111_2222_3333_4444 -> mem_en once with mem_addr=0, im_ready at t+4, im_rdata=0x1111_2222.
REQ-035 dm_write addr=0x010, wdata=0xDEAD_BEEF_0000_0001, then dm_read addr=0x010 -> mem_we=1 with mem_addr=2; dm_ready for each access; dm_rdata=0xDEAD_BEEF_0000_0001.
REQ-036 im_req and dm_read held together from reset release -> grants DM, IM, DM, IM in order; no master granted twice in a row.
REQ-037 reset=0 during WAIT of a DM read -> all outputs 0 at once, no dm_ready; after release, busy stays 0 with no requests.
REQ-038 dm_read and dm_write both high, addr=0x008 -> mem_we=1, dm_rdata unchanged.
REQ-039 LAT=1 and LAT=7 builds, single IM fetch -> im_ready at t+3 and t+9 respectively.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-fetch port, the data port and the unified memory
// port of mem_arbiter.
//   slave  : view taken by the arbiter (requests in, responses/memory strobes out)
//   master : view taken by the requesters and memory model (the opposite view)
// Parameters: N  - data width of the DM path and the memory (>= 64)
//             AW - byte-address width of im_addr / dm_addr
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int N  = 64,
  parameter int AW = 10
);
  // Instruction fetch port
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata;
  logic          im_ready;
  // Data port
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [N-1:0]  dm_wdata;
  logic [N-1:0]  dm_rdata;
  logic          dm_ready;
  // Unified memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-4:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;
  // Status
  logic          busy;

  modport slave (
    input  im_req, im_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output im_rdata, im_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output im_req, im_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  im_rdata, im_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one fixed-latency memory between an instruction-fetch master (IM) and
// a data master (DM). One access at a time walks IDLE -> ISSUE -> WAIT -> RESP;
// ties are broken round-robin.
// Ports:
//   CLOCK_50 - single clock, rising edge
//   reset    - asynchronous, active-low
//   bus      - mem_arbiter_if.slave: IM/DM request and response signals,
//              memory strobe/address/write data, memory read data, busy
// Parameters: N (data width), AW (byte-address width), LAT (1..7, memory
//             read latency in cycles after the mem_en cycle)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int N   = 64,
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  // Grant bookkeeping: 1 = DM, 0 = IM
  logic          last_dm_q, last_dm_d;
  logic          gnt_dm_q, gnt_dm_d;
  // Latched request
  logic          we_q, we_d;
  logic          hi_q, hi_d;          // IM fetch takes the upper 32-bit half
  logic [AW-4:0] addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  // Output registers
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          im_ready_q, im_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic          busy_q, busy_d;
  logic [31:0]   im_rdata_q, im_rdata_d;
  logic [N-1:0]  dm_rdata_q, dm_rdata_d;

  logic          im_pend_s, dm_pend_s, req_s, pick_dm_s;

  // Arbitration: DM wins when alone, or on a tie when IM was granted last
  always_comb begin
    im_pend_s = bus.im_req;
    dm_pend_s = bus.dm_read | bus.dm_write;
    req_s     = im_pend_s | dm_pend_s;
    pick_dm_s = dm_pend_s & (~im_pend_s | ~last_dm_q);
  end

  // FSM state register and latency counter
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 3'(LAT - 1);
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are computed one cycle ahead so
  // that every output comes straight from a flop
  always_comb begin
    last_dm_d  = last_dm_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    im_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    im_rdata_d = im_rdata_q;
    dm_rdata_d = dm_rdata_q;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          gnt_dm_d  = pick_dm_s;
          last_dm_d = pick_dm_s;
          mem_en_d  = 1'b1;
          if (pick_dm_s) begin
            // read+write together is a write
            addr_d   = bus.dm_addr[AW-1:3];
            we_d     = bus.dm_write;
            hi_d     = 1'b0;
            wdata_d  = bus.dm_wdata;
            mem_we_d = bus.dm_write;
          end else begin
            addr_d   = bus.im_addr[AW-1:3];
            we_d     = 1'b0;
            hi_d     = bus.im_addr[2];
            wdata_d  = wdata_q;
            mem_we_d = 1'b0;
          end
        end else begin
          mem_en_d = 1'b0;
        end
      end
      S_WAIT: begin
        // Last WAIT cycle: memory data is valid now
        if (cnt_q == 3'd0) begin
          if (gnt_dm_q) begin
            dm_ready_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = bus.mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            im_ready_d = 1'b1;
            im_rdata_d = hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
          end
        end else begin
          im_ready_d = 1'b0;
        end
      end
      default: begin
        mem_en_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything, aborting any access
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      last_dm_q  <= 1'b0;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      hi_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      im_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      im_rdata_q <= 32'd0;
      dm_rdata_q <= '0;
    end else begin
      last_dm_q  <= last_dm_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      im_ready_q <= im_ready_d;
      dm_ready_q <= dm_ready_d;
      busy_q     <= busy_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.im_ready  = im_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.im_rdata  = im_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int N   = 64;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N(N), .AW(AW)) bus  ();
  mem_arbiter_if #(.N(N), .AW(AW)) bus1 ();
  mem_arbiter_if #(.N(N), .AW(AW)) bus7 ();

  mem_arbiter #(.N(N), .AW(AW), .LAT(LAT)) dut  (.CLOCK_50(clk), .reset(rst_n), .bus(bus));
  mem_arbiter #(.N(N), .AW(AW), .LAT(1))   dut1 (.CLOCK_50(clk), .reset(rst_n), .bus(bus1));
  mem_arbiter #(.N(N), .AW(AW), .LAT(7))   dut7 (.CLOCK_50(clk), .reset(rst_n), .bus(bus7));

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [63:0] ref_mem [128];
  bit          ref_last_dm;
  logic [31:0] exp_im;
  logic [63:0] exp_dm;

  // Memory emulator: read data only valid in the LAT-th cycle after mem_en
  logic [63:0] emu_mem [128];
  int          cd     = 0;
  logic [6:0]  pend_a = 7'd0;
  logic [63:0] junk   = 64'd0;

  always @(posedge clk) begin
    junk <= {$urandom, $urandom};
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) emu_mem[i] <= ref_mem[i];
      cd <= 0;
    end else begin
      if (cd > 0) cd <= cd - 1;
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we === 1'b1) emu_mem[bus.mem_addr] <= bus.mem_wdata;
        else begin
          cd     <= LAT;
          pend_a <= bus.mem_addr;
        end
      end
    end
  end

  assign bus.mem_rdata  = (cd == 1) ? emu_mem[pend_a] : junk;
  assign bus1.mem_rdata = 64'h1111_2222_3333_4444;
  assign bus7.mem_rdata = 64'h1111_2222_3333_4444;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fetch(input logic [9:0] a);
    logic [63:0] w;
    w = ref_mem[a[9:3]];
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " mem_en"},    64'(bus.mem_en),    64'd0);
    chk({tag, " mem_we"},    64'(bus.mem_we),    64'd0);
    chk({tag, " im_ready"},  64'(bus.im_ready),  64'd0);
    chk({tag, " dm_ready"},  64'(bus.dm_ready),  64'd0);
    chk({tag, " busy"},      64'(bus.busy),      64'd0);
    chk({tag, " im_rdata"},  64'(bus.im_rdata),  64'd0);
    chk({tag, " dm_rdata"},  bus.dm_rdata,       64'd0);
    chk({tag, " mem_addr"},  64'(bus.mem_addr),  64'd0);
    chk({tag, " mem_wdata"}, bus.mem_wdata,      64'd0);
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    chk({tag, " idle busy"},  64'(bus.busy),     64'd0);
    chk({tag, " idle ready"}, 64'({bus.im_ready, bus.dm_ready}), 64'd0);
  endtask

  // Follow one access until the granted master's ready pulse (bounded)
  task automatic serve(input bit exp_dm, input int exp_n, input logic [6:0] exp_ma,
                       input bit exp_we, input logic [63:0] exp_wd, input string tag);
    int n = 0, en_n = 0, en_at = 0;
    bit done = 0, stray = 0, addr_bad = 0, we_seen = 0;
    logic [63:0] wd_seen = 64'd0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_en === 1'b1) begin
        en_n++;
        en_at   = n;
        we_seen = bus.mem_we;
        wd_seen = bus.mem_wdata;
      end
      if (n >= exp_n - LAT - 1 && bus.mem_addr !== exp_ma) addr_bad = 1;
      if ((exp_dm ? bus.im_ready : bus.dm_ready) !== 1'b0) stray = 1;
      if ((exp_dm ? bus.dm_ready : bus.im_ready) === 1'b1) done = 1;
    end
    chk({tag, " ready latency"}, 64'(n),       64'(exp_n));
    chk({tag, " mem_en count"},  64'(en_n),    64'd1);
    chk({tag, " mem_en cycle"},  64'(en_at),   64'(exp_n - LAT - 1));
    chk({tag, " mem_we"},        64'(we_seen), 64'(exp_we));
    chk({tag, " mem_addr held"}, 64'(addr_bad), 64'd0);
    chk({tag, " other ready"},   64'(stray),   64'd0);
    if (exp_we) chk({tag, " mem_wdata"}, wd_seen, exp_wd);
  endtask

  // Model one access from the rules, run it, check the response registers
  task automatic do_access(input bit is_dm, input int exp_n, input logic [9:0] ia,
                           input logic [9:0] da, input bit wr, input logic [63:0] wd,
                           input bit keep, input string tag);
    if (is_dm) begin
      serve(1'b1, exp_n, da[9:3], wr, wd, tag);
      if (wr) ref_mem[da[9:3]] = wd;
      else    exp_dm = ref_mem[da[9:3]];
      ref_last_dm = 1'b1;
      if (!keep) begin
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
      end
    end else begin
      serve(1'b0, exp_n, ia[9:3], 1'b0, 64'd0, tag);
      exp_im      = ref_fetch(ia);
      ref_last_dm = 1'b0;
      if (!keep) bus.im_req = 1'b0;
    end
    chk({tag, " im_rdata"}, 64'(bus.im_rdata), 64'(exp_im));
    chk({tag, " dm_rdata"}, bus.dm_rdata,      exp_dm);
  endtask

  initial begin
    bit          im_on, dm_on, first_dm, wr;
    int          kind, r1, r7;
    logic [9:0]  ia, da;
    logic [63:0] wd;
    logic [31:0] d1, d7;

    for (int i = 0; i < 128; i++) ref_mem[i] = {$urandom, $urandom};
    ref_mem[0] = 64'h1111_2222_3333_4444;
    ref_last_dm = 1'b0;
    exp_im = 32'd0;
    exp_dm = 64'd0;
    {bus.im_req, bus.dm_read, bus.dm_write}    = 3'b000;
    {bus1.im_req, bus1.dm_read, bus1.dm_write} = 3'b000;
    {bus7.im_req, bus7.dm_read, bus7.dm_write} = 3'b000;
    bus.im_addr = 10'd0;  bus.dm_addr = 10'd0;  bus.dm_wdata = 64'd0;
    bus1.im_addr = 10'd0; bus1.dm_addr = 10'd0; bus1.dm_wdata = 64'd0;
    bus7.im_addr = 10'd0; bus7.dm_addr = 10'd0; bus7.dm_wdata = 64'd0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Fetch of the upper half from word 0, request present on the release edge
    bus.im_req = 1'b1; bus.im_addr = 10'h004;
    rst_n = 1'b1;
    do_access(1'b0, LAT + 2, 10'h004, 10'd0, 1'b0, 64'd0, 1'b0, "im fetch");
    chk("im fetch word", 64'(bus.im_rdata), 64'h1111_2222);
    idle_gap("im fetch");

    // Store then load back the same doubleword
    bus.dm_write = 1'b1; bus.dm_addr = 10'h010; bus.dm_wdata = 64'hDEAD_BEEF_0000_0001;
    do_access(1'b1, LAT + 2, 10'd0, 10'h010, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, "dm write");
    idle_gap("dm write");
    bus.dm_read = 1'b1; bus.dm_addr = 10'h010;
    do_access(1'b1, LAT + 2, 10'd0, 10'h010, 1'b0, 64'd0, 1'b0, "dm read");
    chk("dm read word", bus.dm_rdata, 64'hDEAD_BEEF_0000_0001);
    idle_gap("dm read");

    // Read and write together behave as a write
    wd = {$urandom, $urandom};
    bus.dm_read = 1'b1; bus.dm_write = 1'b1; bus.dm_addr = 10'h008; bus.dm_wdata = wd;
    do_access(1'b1, LAT + 2, 10'd0, 10'h008, 1'b1, wd, 1'b0, "dm rd+wr");
    chk("dm rd+wr keeps rdata", bus.dm_rdata, 64'hDEAD_BEEF_0000_0001);
    idle_gap("dm rd+wr");

    // Reset during WAIT of a DM read aborts it
    begin
      bit rdy = 0;
      bus.dm_read = 1'b1; bus.dm_addr = 10'h018;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      bus.dm_read = 1'b0;
      #1;
      chk_zero("abort");
      repeat (3) begin
        @(negedge clk);
        if (bus.dm_ready !== 1'b0) rdy = 1;
      end
      chk("abort no dm_ready", 64'(rdy), 64'd0);
      rst_n = 1'b1;
      ref_last_dm = 1'b0; exp_im = 32'd0; exp_dm = 64'd0;
      rdy = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.busy !== 1'b0) rdy = 1;
      end
      chk("abort stays idle", 64'(rdy), 64'd0);
    end

    // Both held from reset release: DM, IM, DM, IM
    rst_n = 1'b0;
    @(negedge clk);
    ref_last_dm = 1'b0; exp_im = 32'd0; exp_dm = 64'd0;
    bus.im_req = 1'b1; bus.im_addr = 10'h02C;
    bus.dm_read = 1'b1; bus.dm_addr = 10'h040;
    rst_n = 1'b1;
    do_access(1'b1, LAT + 2, 10'h02C, 10'h040, 1'b0, 64'd0, 1'b1, "rr1 dm");
    do_access(1'b0, LAT + 3, 10'h02C, 10'h040, 1'b0, 64'd0, 1'b1, "rr2 im");
    do_access(1'b1, LAT + 3, 10'h02C, 10'h040, 1'b0, 64'd0, 1'b1, "rr3 dm");
    do_access(1'b0, LAT + 3, 10'h02C, 10'h040, 1'b0, 64'd0, 1'b0, "rr4 im");
    bus.dm_read = 1'b0;
    idle_gap("rr");

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      im_on = 1'($urandom_range(0, 1));
      dm_on = 1'($urandom_range(0, 1));
      if (!im_on && !dm_on) im_on = 1'b1;
      kind = int'($urandom_range(0, 2));
      ia = 10'($urandom_range(0, 1023));
      da = 10'($urandom_range(0, 1023));
      wd = {$urandom, $urandom};
      wr = dm_on && (kind != 0);
      bus.im_req   = im_on;        bus.im_addr = ia;
      bus.dm_read  = dm_on && (kind != 1);
      bus.dm_write = wr;
      bus.dm_addr  = da;           bus.dm_wdata = wd;
      first_dm = dm_on && (!im_on || !ref_last_dm);
      do_access(first_dm, LAT + 2, ia, da, wr, wd, 1'b0, "rand first");
      if (im_on && dm_on)
        do_access(!first_dm, LAT + 3, ia, da, wr, wd, 1'b0, "rand second");
      idle_gap("rand");
    end

    // Latency of the LAT=1 and LAT=7 builds
    r1 = 0; r7 = 0; d1 = 32'd0; d7 = 32'd0;
    bus1.im_req = 1'b1; bus1.im_addr = 10'h004;
    bus7.im_req = 1'b1; bus7.im_addr = 10'h004;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (r1 == 0 && bus1.im_ready === 1'b1) begin r1 = n; d1 = bus1.im_rdata; bus1.im_req = 1'b0; end
      if (r7 == 0 && bus7.im_ready === 1'b1) begin r7 = n; d7 = bus7.im_rdata; bus7.im_req = 1'b0; end
    end
    chk("lat1 ready latency", 64'(r1), 64'd3);
    chk("lat7 ready latency", 64'(r7), 64'd9);
    chk("lat1 im_rdata", 64'(d1), 64'h1111_2222);
    chk("lat7 im_rdata", 64'(d7), 64'h1111_2222);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
